// File: rtl/transformer_pkg.sv
// transformer_pkg: table types, default prediction/scan tables and elaboration checks for transformer_pipe
package transformer_pkg;
  localparam int MAX_MODE = 16;
  localparam int MAX_ELEM = 64;
  localparam int MAX_W = 16;
  localparam int MAX_BW = MAX_ELEM * MAX_W;
  localparam int DEF_ROOT_IDX = 21;
  typedef logic [MAX_MODE-1:0][MAX_ELEM-1:0][7:0] idx_tab_t;
  typedef logic [MAX_BW-1:0][7:0] scan_tab_t;
  function automatic int bw(int w, int n);
    return w * n;
  endfunction
  // Mode 0: all from root; 1: previous element; 2: first of each group of 4; 3: element i/2
  function automatic idx_tab_t def_base();
    idx_tab_t t = '0;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < MAX_ELEM; i++)
        t[m][i] = 8'(m == 0 ? DEF_ROOT_IDX : m == 1 ? (i == 0 ? DEF_ROOT_IDX : i - 1) : m == 2 ? (i & ~3) : (i >> 1));
    return t;
  endfunction
  function automatic scan_tab_t def_scan(int n, bit col);
    scan_tab_t t;
    for (int k = 0; k < MAX_BW; k++) t[k] = 8'(col ? k % n : k / n);
    return t;
  endfunction
  // SCAN must be a bijection onto the (row, col) grid: in range, no repeats, BW entries
  function automatic bit tables_ok(int w, int n, int nm, int mw, int root, idx_tab_t base, idx_tab_t shf,
                                   scan_tab_t row, scan_tab_t col);
    logic [MAX_BW-1:0] seen = '0;
    bit ok = w >= 2 && w <= MAX_W && n >= 1 && n <= MAX_ELEM && nm >= 1 && nm <= MAX_MODE &&
             mw >= 1 && (mw >= 31 || (1 << mw) >= nm) && root >= 0 && root < n;
    int r;
    int c;
    for (int m = 0; m < nm && m < MAX_MODE; m++)
      for (int i = 0; i < n && i < MAX_ELEM; i++)
        if (32'(base[m][i]) >= 32'(n) || 32'(shf[m][i]) >= 32'(w)) ok = 1'b0;
    for (int k = 0; k < w * n && k < MAX_BW; k++) begin
      r = 32'(row[k]);
      c = 32'(col[k]);
      if (r >= w || c >= n) ok = 1'b0;
      else if (seen[10'(r * n + c)]) ok = 1'b0;
      else seen[10'(r * n + c)] = 1'b1;
    end
    return ok;
  endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid/ready register slice with a parametrised payload
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
endmodule

// File: rtl/transformer_pipe.sv
// transformer_pipe: three-stage predict/subtract, delta-bitplane-XOR and bit-scan block transformer
module transformer_pipe import transformer_pkg::*; #(
  parameter int        ELEM_W    = 8,
  parameter int        NUM_ELEM  = 32,
  parameter int        NUM_MODE  = 4,
  parameter int        MODE_W    = 2,
  parameter int        TAG_W     = 4,
  parameter int        ROOT_IDX  = DEF_ROOT_IDX,
  parameter idx_tab_t  BASE_IDX  = def_base(),
  parameter idx_tab_t  SHIFT_VAL = '0,
  parameter scan_tab_t SCAN_ROW  = def_scan(NUM_ELEM, 1'b0),
  parameter scan_tab_t SCAN_COL  = def_scan(NUM_ELEM, 1'b1),
  localparam int       BW        = bw(ELEM_W, NUM_ELEM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW-1:0]     data_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              bypass_o
);
  localparam int PW = BW + TAG_W + 1;
  logic [ELEM_W-1:0] w_e [NUM_ELEM];
  logic [ELEM_W-1:0] w_d [NUM_ELEM];
  logic [BW-1:0]     w_v, w_x, w_y, w_s1_d, w_s2_d;
  logic [TAG_W-1:0]  w_s1_tag, w_s2_tag;
  logic              w_byp, w_s1_byp, w_s2_byp, w_s1_v, w_s2_v, w_s1_r, w_s2_r;

  if (!tables_ok(ELEM_W, NUM_ELEM, NUM_MODE, MODE_W, ROOT_IDX, BASE_IDX, SHIFT_VAL, SCAN_ROW, SCAN_COL)) begin : g_bad
    $fatal(1, "transformer_pipe: table index out of range or SCAN is not a permutation");
  end

  assign w_byp = 32'(mode_i) >= 32'(NUM_MODE);

  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_pred
    logic [ELEM_W-1:0] w_c [NUM_MODE];
    logic [ELEM_W-1:0] w_m;
    assign w_e[i] = data_i[BW-1-i*ELEM_W -: ELEM_W];
    for (genvar m = 0; m < NUM_MODE; m++) begin : g_mode
      localparam int B = 32'(BASE_IDX[m][i]);
      if (i == ROOT_IDX) begin : g_root
        assign w_c[m] = w_e[i];
      end else begin : g_sub
        assign w_c[m] = w_e[i] - (w_e[B] >> SHIFT_VAL[m][i]);
      end
    end
    always_comb begin
      w_m = w_c[0];
      for (int m = 0; m < NUM_MODE; m++) if (32'(mode_i) == 32'(m)) w_m = w_c[m];
    end
    assign w_d[i] = w_m;
  end

  // Root difference leads the vector; the rest keep ascending order
  for (genvar j = 0; j < NUM_ELEM; j++) begin : g_vec
    localparam int SRC = j == 0 ? ROOT_IDX : (j <= ROOT_IDX ? j - 1 : j);
    assign w_v[BW-1-j*ELEM_W -: ELEM_W] = w_d[SRC];
  end

  pipe_stage_reg #(.W(PW)) u_s1 (
    .clk(clk), .rst(rst),
    .i_valid(in_valid), .o_ready(in_ready), .i_data({w_byp, tag_i, w_byp ? data_i : w_v}),
    .o_valid(w_s1_v), .i_ready(w_s1_r), .o_data({w_s1_byp, w_s1_tag, w_s1_d})
  );

  // X row r holds plane p = ELEM_W-1-r, stored row-major with column 0 at the MSB
  for (genvar r = 0; r < ELEM_W; r++) begin : g_row
    for (genvar j = 0; j < NUM_ELEM; j++) begin : g_col
      localparam int B = (NUM_ELEM - 1 - j) * ELEM_W + ELEM_W - 1 - r;
      if (r == 0) begin : g_top
        assign w_x[BW-1-(r*NUM_ELEM+j)] = w_s1_d[B];
      end else begin : g_xor
        assign w_x[BW-1-(r*NUM_ELEM+j)] = w_s1_d[B] ^ w_s1_d[B+1];
      end
    end
  end

  pipe_stage_reg #(.W(PW)) u_s2 (
    .clk(clk), .rst(rst),
    .i_valid(w_s1_v), .o_ready(w_s1_r), .i_data({w_s1_byp, w_s1_tag, w_s1_byp ? w_s1_d : w_x}),
    .o_valid(w_s2_v), .i_ready(w_s2_r), .o_data({w_s2_byp, w_s2_tag, w_s2_d})
  );

  for (genvar k = 0; k < BW; k++) begin : g_scan
    localparam int SRC = 32'(SCAN_ROW[k]) * NUM_ELEM + 32'(SCAN_COL[k]);
    assign w_y[BW-1-k] = w_s2_d[BW-1-SRC];
  end

  pipe_stage_reg #(.W(PW)) u_s3 (
    .clk(clk), .rst(rst),
    .i_valid(w_s2_v), .o_ready(w_s2_r), .i_data({w_s2_byp, w_s2_tag, w_s2_byp ? w_s2_d : w_y}),
    .o_valid(out_valid), .i_ready(out_ready), .o_data({bypass_o, tag_o, data_o})
  );
endmodule
